// File: rtl/pim_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pim_mem_arbiter
//
// Front end that lets NUM_PORTS requesters (port 0 = RISC-V core, the others
// PIM engines / DMA) share one on-chip RAM port. Each requester uses the
// core-style strobe bus: a one-cycle nonzero wmask starts a write, a one-cycle
// rstrb starts a read. The request is latched per port, a single winner is
// picked (round-robin or fixed priority, optionally restricted to one forced
// port) and its access is replayed onto the RAM port.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   req_addr       NUM_PORTS x 32 byte address (port p at [32p+31:32p])
//   req_wdata      NUM_PORTS x 32 write data
//   req_wmask      NUM_PORTS x 4  byte mask, nonzero = write strobe
//   req_rstrb      NUM_PORTS      read strobe
//   req_rdata      NUM_PORTS x 32 per-port read data register
//   req_rbusy      NUM_PORTS      read pending
//   req_wbusy      NUM_PORTS      write pending
//   force_en       restrict arbitration to force_port
//   force_port     forced port index
//   ram_addr       RAM word address (byte address [ADDR_W+1:2])
//   ram_wdata      RAM write data
//   ram_wen        RAM write enable (single cycle)
//   ram_rden       RAM read enable (single cycle)
//   ram_byteena    RAM byte enables (wmask on write, all ones on read)
//   ram_rdata      RAM read data, valid RD_LAT cycles after ram_rden
//   active_port    index of the most recently granted port
// -----------------------------------------------------------------------------
module pim_mem_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 10,
   parameter int RD_LAT    = 1,
   parameter int ARB_MODE  = 0,
   localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_PORTS*32-1:0]   req_addr,
   input  logic [NUM_PORTS*32-1:0]   req_wdata,
   input  logic [NUM_PORTS*4-1:0]    req_wmask,
   input  logic [NUM_PORTS-1:0]      req_rstrb,
   output logic [NUM_PORTS*32-1:0]   req_rdata,
   output logic [NUM_PORTS-1:0]      req_rbusy,
   output logic [NUM_PORTS-1:0]      req_wbusy,
   input  logic                      force_en,
   input  logic [PW-1:0]             force_port,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic [31:0]               ram_wdata,
   output logic                      ram_wen,
   output logic                      ram_rden,
   output logic [3:0]                ram_byteena,
   input  logic [31:0]               ram_rdata,
   output logic [PW-1:0]             active_port
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   // Last WAIT cycle: RAM data is valid and gets captured.
   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   // Per-port latched requests
   logic [NUM_PORTS-1:0]   pend_wr_r;
   logic [NUM_PORTS-1:0]   pend_rd_r;
   logic [ADDR_W-1:0]      addr_r  [NUM_PORTS];
   logic [31:0]            wdata_r [NUM_PORTS];
   logic [3:0]             wmask_r [NUM_PORTS];

   // Arbiter / sequencer state
   logic [1:0]             state_r;
   logic [PW-1:0]          win_r;
   logic [PW-1:0]          last_grant_r;
   logic                   is_wr_r;
   logic [1:0]             lat_cnt_r;

   // RAM-side output registers
   logic [ADDR_W-1:0]      ram_addr_r;
   logic [31:0]            ram_wdata_r;
   logic                   ram_wen_r;
   logic                   ram_rden_r;
   logic [3:0]             ram_byteena_r;
   logic [NUM_PORTS*32-1:0] rdata_r;

   // Combinational arbitration
   logic [NUM_PORTS-1:0]   force_mask_s;
   logic [NUM_PORTS-1:0]   eligible_s;
   logic [2*NUM_PORTS-1:0] dbl_s;
   logic [NUM_PORTS-1:0]   rot_s;
   int                     rr_idx_s;
   logic                   win_found_s;
   logic [PW-1:0]          win_idx_s;
   logic                   done_wr_s;
   logic                   done_rd_s;
   logic [NUM_PORTS-1:0]   clear_s;

   // Eligibility: pending ports, optionally narrowed to the forced port.
   always_comb begin
      force_mask_s = {NUM_PORTS{1'b1}};
      if (force_en) begin
         force_mask_s = {{(NUM_PORTS-1){1'b0}}, 1'b1} << force_port;
      end else begin
         force_mask_s = {NUM_PORTS{1'b1}};
      end
      eligible_s = (pend_wr_r | pend_rd_r) & force_mask_s;
   end

   // Winner selection. Round-robin rotates the eligible vector so that
   // bit 0 is last_grant+1, then takes the lowest set bit; the doubled
   // vector makes the rotation a plain right shift.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = {PW{1'b0}};
      rr_idx_s    = 0;
      dbl_s       = {eligible_s, eligible_s} >> ({1'b0, last_grant_r} + {{PW{1'b0}}, 1'b1});
      rot_s       = dbl_s[NUM_PORTS-1:0];
      if (ARB_MODE == 1) begin
         for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            if (eligible_s[j]) begin
               win_found_s = 1'b1;
               win_idx_s   = PW'(j);
            end else begin
               win_found_s = win_found_s;
            end
         end
      end else begin
         for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            if (rot_s[j]) begin
               win_found_s = 1'b1;
               rr_idx_s    = int'(last_grant_r) + 1 + j;
            end else begin
               win_found_s = win_found_s;
            end
         end
         if (rr_idx_s >= NUM_PORTS) begin
            rr_idx_s = rr_idx_s - NUM_PORTS;
         end else begin
            rr_idx_s = rr_idx_s;
         end
         win_idx_s = rr_idx_s[PW-1:0];
      end
   end

   // Completion events and the per-port pending clear they cause.
   always_comb begin
      done_wr_s = (state_r == ST_ISSUE) && is_wr_r;
      done_rd_s = (state_r == ST_WAIT) && (lat_cnt_r == LAT_LAST);
      clear_s   = {NUM_PORTS{1'b0}};
      for (int p = 0; p < NUM_PORTS; p++) begin
         clear_s[p] = (done_wr_s || done_rd_s) && (win_r == PW'(p));
      end
   end

   // Per-port request capture. A port only accepts a new strobe while it has
   // nothing pending; a write strobe wins over a simultaneous read strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_wr_r <= {NUM_PORTS{1'b0}};
         pend_rd_r <= {NUM_PORTS{1'b0}};
         for (int p = 0; p < NUM_PORTS; p++) begin
            addr_r[p]  <= {ADDR_W{1'b0}};
            wdata_r[p] <= 32'h0000_0000;
            wmask_r[p] <= 4'h0;
         end
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (pend_wr_r[p] || pend_rd_r[p]) begin
               if (clear_s[p]) begin
                  pend_wr_r[p] <= 1'b0;
                  pend_rd_r[p] <= 1'b0;
               end
            end else if (req_wmask[4*p +: 4] != 4'h0) begin
               addr_r[p]    <= req_addr[32*p+2 +: ADDR_W];
               wdata_r[p]   <= req_wdata[32*p +: 32];
               wmask_r[p]   <= req_wmask[4*p +: 4];
               pend_wr_r[p] <= 1'b1;
            end else if (req_rstrb[p]) begin
               addr_r[p]    <= req_addr[32*p+2 +: ADDR_W];
               pend_rd_r[p] <= 1'b1;
            end
         end
      end
   end

   // Access sequencer: IDLE grants and loads the RAM registers, so the
   // enable is high for exactly the ISSUE cycle; reads then wait RD_LAT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         win_r         <= {PW{1'b0}};
         last_grant_r  <= PW'(NUM_PORTS - 1);
         is_wr_r       <= 1'b0;
         lat_cnt_r     <= 2'd0;
         ram_addr_r    <= {ADDR_W{1'b0}};
         ram_wdata_r   <= 32'h0000_0000;
         ram_wen_r     <= 1'b0;
         ram_rden_r    <= 1'b0;
         ram_byteena_r <= 4'h0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               ram_wen_r  <= 1'b0;
               ram_rden_r <= 1'b0;
               if (win_found_s) begin
                  ram_addr_r <= addr_r[win_idx_s];
                  if (pend_wr_r[win_idx_s]) begin
                     ram_wen_r     <= 1'b1;
                     ram_wdata_r   <= wdata_r[win_idx_s];
                     ram_byteena_r <= wmask_r[win_idx_s];
                     is_wr_r       <= 1'b1;
                  end else begin
                     ram_rden_r    <= 1'b1;
                     ram_byteena_r <= 4'hF;
                     is_wr_r       <= 1'b0;
                  end
                  win_r        <= win_idx_s;
                  last_grant_r <= win_idx_s;
                  lat_cnt_r    <= 2'd0;
                  state_r      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               ram_wen_r  <= 1'b0;
               ram_rden_r <= 1'b0;
               if (is_wr_r) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               ram_wen_r  <= 1'b0;
               ram_rden_r <= 1'b0;
               if (lat_cnt_r == LAT_LAST) begin
                  state_r <= ST_IDLE;
               end else begin
                  lat_cnt_r <= lat_cnt_r + 2'd1;
               end
            end
            default: begin
               ram_wen_r  <= 1'b0;
               ram_rden_r <= 1'b0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

   // Read data return: only the granted port's register is updated.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_r <= {(NUM_PORTS*32){1'b0}};
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (done_rd_s && (win_r == PW'(p))) begin
               rdata_r[32*p +: 32] <= ram_rdata;
            end
         end
      end
   end

   assign req_rdata   = rdata_r;
   assign req_rbusy   = pend_rd_r;
   assign req_wbusy   = pend_wr_r;
   assign ram_addr    = ram_addr_r;
   assign ram_wdata   = ram_wdata_r;
   assign ram_wen     = ram_wen_r;
   assign ram_rden    = ram_rden_r;
   assign ram_byteena = ram_byteena_r;
   assign active_port = win_r;

endmodule

// File: tb/tb_pim_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pim_mem_arbiter
//
// Two instances share all requester inputs: one round-robin, one fixed
// priority. Each has its own RAM model with one cycle read latency.
// Inputs are driven right after a falling edge and outputs are sampled on
// falling edges; "cycle 0" is the cycle in which a strobe is presented.
// -----------------------------------------------------------------------------
module tb_pim_mem_arbiter;

   localparam int NP = 2;
   localparam int AW = 10;

   logic              clk;
   logic              rst;
   logic [NP*32-1:0]  req_addr;
   logic [NP*32-1:0]  req_wdata;
   logic [NP*4-1:0]   req_wmask;
   logic [NP-1:0]     req_rstrb;
   logic              force_en;
   logic [0:0]        force_port;

   logic [NP*32-1:0]  req_rdata_rr,  req_rdata_fp;
   logic [NP-1:0]     req_rbusy_rr,  req_rbusy_fp;
   logic [NP-1:0]     req_wbusy_rr,  req_wbusy_fp;
   logic [AW-1:0]     ram_addr_rr,   ram_addr_fp;
   logic [31:0]       ram_wdata_rr,  ram_wdata_fp;
   logic              ram_wen_rr,    ram_wen_fp;
   logic              ram_rden_rr,   ram_rden_fp;
   logic [3:0]        ram_byteena_rr, ram_byteena_fp;
   logic [31:0]       ram_rdata_rr,  ram_rdata_fp;
   logic [0:0]        active_port_rr, active_port_fp;

   logic [31:0] mem_rr [0:1023];
   logic [31:0] mem_fp [0:1023];

   int cnt_cmp;
   int cnt_err;
   int grants_rr[$];
   int grants_fp[$];

   pim_mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .RD_LAT(1), .ARB_MODE(0)) dut (
      .clk(clk), .rst(rst),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .req_rstrb(req_rstrb),
      .req_rdata(req_rdata_rr), .req_rbusy(req_rbusy_rr), .req_wbusy(req_wbusy_rr),
      .force_en(force_en), .force_port(force_port),
      .ram_addr(ram_addr_rr), .ram_wdata(ram_wdata_rr), .ram_wen(ram_wen_rr), .ram_rden(ram_rden_rr),
      .ram_byteena(ram_byteena_rr), .ram_rdata(ram_rdata_rr), .active_port(active_port_rr)
   );

   pim_mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .RD_LAT(1), .ARB_MODE(1)) dut_fp (
      .clk(clk), .rst(rst),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .req_rstrb(req_rstrb),
      .req_rdata(req_rdata_fp), .req_rbusy(req_rbusy_fp), .req_wbusy(req_wbusy_fp),
      .force_en(force_en), .force_port(force_port),
      .ram_addr(ram_addr_fp), .ram_wdata(ram_wdata_fp), .ram_wen(ram_wen_fp), .ram_rden(ram_rden_fp),
      .ram_byteena(ram_byteena_fp), .ram_rdata(ram_rdata_fp), .active_port(active_port_fp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem_rr[i] = 32'h0;
         mem_fp[i] = 32'h0;
      end
   end

   // RAM models: byte-enabled write, one cycle registered read
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (ram_wen_rr && ram_byteena_rr[b]) mem_rr[ram_addr_rr][8*b +: 8] <= ram_wdata_rr[8*b +: 8];
         if (ram_wen_fp && ram_byteena_fp[b]) mem_fp[ram_addr_fp][8*b +: 8] <= ram_wdata_fp[8*b +: 8];
      end
      if (ram_rden_rr) ram_rdata_rr <= mem_rr[ram_addr_rr];
      if (ram_rden_fp) ram_rdata_fp <= mem_fp[ram_addr_fp];
   end

   // Grant log: which port each RAM read was issued for
   always @(negedge clk) begin
      if (ram_rden_rr === 1'b1) grants_rr.push_back(int'(active_port_rr));
      if (ram_rden_fp === 1'b1) grants_fp.push_back(int'(active_port_fp));
   end

   task automatic clr_in();
      req_addr  = '0;
      req_wdata = '0;
      req_wmask = '0;
      req_rstrb = '0;
   endtask

   task automatic drive_port(input int p, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] m, input logic r);
      req_addr[32*p +: 32]  = a;
      req_wdata[32*p +: 32] = d;
      req_wmask[4*p +: 4]   = m;
      req_rstrb[p]          = r;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      force_en = 1'b0;
      force_port = 1'b0;
      clr_in();
      cycles(3);
      rst = 1'b0;
      cycles(1);
      cnt_cmp++; if (req_rbusy_rr !== 2'b00) begin cnt_err++; $display("FAIL rst_rbusy got=%0h exp=0", req_rbusy_rr); end
      cnt_cmp++; if (req_wbusy_rr !== 2'b00) begin cnt_err++; $display("FAIL rst_wbusy got=%0h exp=0", req_wbusy_rr); end
      cnt_cmp++; if (req_rdata_rr !== 64'h0) begin cnt_err++; $display("FAIL rst_rdata got=%0h exp=0", req_rdata_rr); end
      cnt_cmp++; if (ram_wen_rr !== 1'b0 || ram_rden_rr !== 1'b0) begin cnt_err++; $display("FAIL rst_strobes got=%b%b exp=00", ram_wen_rr, ram_rden_rr); end
      cnt_cmp++; if (ram_addr_rr !== 10'h0 || ram_wdata_rr !== 32'h0 || ram_byteena_rr !== 4'h0) begin cnt_err++; $display("FAIL rst_ramregs got=%0h/%0h/%0h exp=0/0/0", ram_addr_rr, ram_wdata_rr, ram_byteena_rr); end
      cnt_cmp++; if (active_port_rr !== 1'b0) begin cnt_err++; $display("FAIL rst_active got=%0h exp=0", active_port_rr); end
   endtask

   task automatic test_write();
      drive_port(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
      cycles(1);  // cycle 1
      clr_in();
      cnt_cmp++; if (req_wbusy_rr[0] !== 1'b1) begin cnt_err++; $display("FAIL wr_wbusy_c1 got=%0h exp=1", req_wbusy_rr[0]); end
      cnt_cmp++; if (ram_wen_rr !== 1'b0) begin cnt_err++; $display("FAIL wr_wen_c1 got=%0h exp=0", ram_wen_rr); end
      cycles(1);  // cycle 2
      cnt_cmp++; if (req_wbusy_rr[0] !== 1'b1) begin cnt_err++; $display("FAIL wr_wbusy_c2 got=%0h exp=1", req_wbusy_rr[0]); end
      cnt_cmp++; if (ram_wen_rr !== 1'b1 || ram_rden_rr !== 1'b0) begin cnt_err++; $display("FAIL wr_wen_c2 got=%b%b exp=10", ram_wen_rr, ram_rden_rr); end
      cnt_cmp++; if (ram_addr_rr !== 10'd4) begin cnt_err++; $display("FAIL wr_addr got=%0h exp=4", ram_addr_rr); end
      cnt_cmp++; if (ram_byteena_rr !== 4'hF) begin cnt_err++; $display("FAIL wr_be got=%0h exp=f", ram_byteena_rr); end
      cnt_cmp++; if (ram_wdata_rr !== 32'hDEADBEEF) begin cnt_err++; $display("FAIL wr_wdata got=%0h exp=deadbeef", ram_wdata_rr); end
      cycles(1);  // cycle 3
      cnt_cmp++; if (req_wbusy_rr[0] !== 1'b0 || ram_wen_rr !== 1'b0) begin cnt_err++; $display("FAIL wr_done_c3 got=%b%b exp=00", req_wbusy_rr[0], ram_wen_rr); end
   endtask

   task automatic test_read();
      drive_port(1, 32'h10, 32'h0, 4'h0, 1'b1);
      cycles(1);  // cycle 1
      clr_in();
      cnt_cmp++; if (req_rbusy_rr[1] !== 1'b1) begin cnt_err++; $display("FAIL rd_rbusy_c1 got=%0h exp=1", req_rbusy_rr[1]); end
      cycles(1);  // cycle 2
      cnt_cmp++; if (ram_rden_rr !== 1'b1 || ram_wen_rr !== 1'b0) begin cnt_err++; $display("FAIL rd_rden_c2 got=%b%b exp=10", ram_rden_rr, ram_wen_rr); end
      cnt_cmp++; if (ram_addr_rr !== 10'd4 || ram_byteena_rr !== 4'hF) begin cnt_err++; $display("FAIL rd_addr_be got=%0h/%0h exp=4/f", ram_addr_rr, ram_byteena_rr); end
      cnt_cmp++; if (active_port_rr !== 1'b1) begin cnt_err++; $display("FAIL rd_active got=%0h exp=1", active_port_rr); end
      cycles(1);  // cycle 3
      cnt_cmp++; if (req_rbusy_rr[1] !== 1'b1 || ram_rden_rr !== 1'b0) begin cnt_err++; $display("FAIL rd_c3 got=%b%b exp=10", req_rbusy_rr[1], ram_rden_rr); end
      cycles(1);  // cycle 4
      cnt_cmp++; if (req_rbusy_rr[1] !== 1'b0) begin cnt_err++; $display("FAIL rd_rbusy_c4 got=%0h exp=0", req_rbusy_rr[1]); end
      cnt_cmp++; if (req_rdata_rr[63:32] !== 32'hDEADBEEF) begin cnt_err++; $display("FAIL rd_rdata1 got=%0h exp=deadbeef", req_rdata_rr[63:32]); end
      cnt_cmp++; if (req_rdata_rr[31:0] !== 32'h0) begin cnt_err++; $display("FAIL rd_rdata0 got=%0h exp=0", req_rdata_rr[31:0]); end
   endtask

   task automatic test_arb_repeat();
      grants_rr.delete();
      grants_fp.delete();
      for (int r = 0; r < 4; r++) begin
         drive_port(0, 32'h10, 32'h0, 4'h0, 1'b1);
         drive_port(1, 32'h10, 32'h0, 4'h0, 1'b1);
         cycles(1);
         clr_in();
         cycles(7);
      end
      cnt_cmp++; if (req_rbusy_rr !== 2'b00) begin cnt_err++; $display("FAIL arb_busy_end got=%0h exp=0", req_rbusy_rr); end
      cnt_cmp++;
      if (grants_rr.size() != 8) begin
         cnt_err++; $display("FAIL arb_rr_count got=%0d exp=8", grants_rr.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            cnt_cmp++; if (grants_rr[i] != (i % 2)) begin cnt_err++; $display("FAIL arb_rr_order[%0d] got=%0d exp=%0d", i, grants_rr[i], i % 2); end
         end
      end
      cnt_cmp++;
      if (grants_fp.size() != 8) begin
         cnt_err++; $display("FAIL arb_fp_count got=%0d exp=8", grants_fp.size());
      end else begin
         for (int i = 0; i < 8; i += 2) begin
            cnt_cmp++; if (grants_fp[i] != 0) begin cnt_err++; $display("FAIL arb_fp_first[%0d] got=%0d exp=0", i, grants_fp[i]); end
         end
      end
   endtask

   task automatic test_rr_vs_fixed();
      grants_rr.delete();
      grants_fp.delete();
      // port 0 write makes it the last grant for both instances
      drive_port(0, 32'h14, 32'h12345678, 4'hF, 1'b0);
      cycles(1);
      clr_in();
      cycles(2);
      drive_port(0, 32'h14, 32'h0, 4'h0, 1'b1);
      drive_port(1, 32'h10, 32'h0, 4'h0, 1'b1);
      cycles(1);
      clr_in();
      cycles(7);
      cnt_cmp++; if (grants_rr.size() != 2 || grants_rr[0] != 1 || grants_rr[1] != 0) begin cnt_err++; $display("FAIL rr_after_p0 got=%0d exp=1,0 (count %0d)", grants_rr.size() > 0 ? grants_rr[0] : -1, grants_rr.size()); end
      cnt_cmp++; if (grants_fp.size() != 2 || grants_fp[0] != 0 || grants_fp[1] != 1) begin cnt_err++; $display("FAIL fp_after_p0 got=%0d exp=0,1 (count %0d)", grants_fp.size() > 0 ? grants_fp[0] : -1, grants_fp.size()); end
      cnt_cmp++; if (req_rdata_rr !== {32'hDEADBEEF, 32'h12345678}) begin cnt_err++; $display("FAIL rr_rdata got=%0h exp=deadbeef12345678", req_rdata_rr); end
      cnt_cmp++; if (req_rdata_fp !== {32'hDEADBEEF, 32'h12345678}) begin cnt_err++; $display("FAIL fp_rdata got=%0h exp=deadbeef12345678", req_rdata_fp); end
   endtask

   task automatic test_force();
      grants_rr.delete();
      grants_fp.delete();
      force_en = 1'b1;
      force_port = 1'b1;
      drive_port(0, 32'h10, 32'h0, 4'h0, 1'b1);
      drive_port(1, 32'h14, 32'h0, 4'h0, 1'b1);
      cycles(1);
      clr_in();
      cycles(7);
      cnt_cmp++; if (req_rbusy_rr !== 2'b01) begin cnt_err++; $display("FAIL force_rr_busy got=%0h exp=1", req_rbusy_rr); end
      cnt_cmp++; if (req_rbusy_fp !== 2'b01) begin cnt_err++; $display("FAIL force_fp_busy got=%0h exp=1", req_rbusy_fp); end
      cnt_cmp++; if (grants_rr.size() != 1 || grants_fp.size() != 1) begin cnt_err++; $display("FAIL force_count got=%0d/%0d exp=1/1", grants_rr.size(), grants_fp.size()); end
      cnt_cmp++; if (req_rdata_rr !== {32'h12345678, 32'h12345678}) begin cnt_err++; $display("FAIL force_rdata got=%0h exp=1234567812345678", req_rdata_rr); end
      force_en = 1'b0;
      cycles(6);
      cnt_cmp++; if (req_rbusy_rr !== 2'b00 || req_rbusy_fp !== 2'b00) begin cnt_err++; $display("FAIL unforce_busy got=%0h/%0h exp=0/0", req_rbusy_rr, req_rbusy_fp); end
      cnt_cmp++; if (grants_fp.size() != 2 || grants_fp[0] != 1 || grants_fp[1] != 0) begin cnt_err++; $display("FAIL unforce_fp_order got count=%0d exp=2 order 1,0", grants_fp.size()); end
      cnt_cmp++; if (req_rdata_rr !== {32'h12345678, 32'hDEADBEEF}) begin cnt_err++; $display("FAIL unforce_rdata got=%0h exp=12345678deadbeef", req_rdata_rr); end
   endtask

   task automatic test_wr_rd_same();
      drive_port(0, 32'h18, 32'hA5A5A5A5, 4'h3, 1'b1);
      cycles(1);  // cycle 1
      cnt_cmp++; if (req_wbusy_rr[0] !== 1'b1 || req_rbusy_rr[0] !== 1'b0) begin cnt_err++; $display("FAIL same_busy_c1 got=w%b r%b exp=w1 r0", req_wbusy_rr[0], req_rbusy_rr[0]); end
      clr_in();
      drive_port(0, 32'h40, 32'h0, 4'h0, 1'b1);  // must be ignored
      cycles(1);  // cycle 2
      clr_in();
      cnt_cmp++; if (ram_wen_rr !== 1'b1 || ram_rden_rr !== 1'b0) begin cnt_err++; $display("FAIL same_wen got=%b%b exp=10", ram_wen_rr, ram_rden_rr); end
      cnt_cmp++; if (ram_byteena_rr !== 4'h3 || ram_addr_rr !== 10'd6) begin cnt_err++; $display("FAIL same_be_addr got=%0h/%0h exp=3/6", ram_byteena_rr, ram_addr_rr); end
      cycles(1);  // cycle 3
      cnt_cmp++; if (req_wbusy_rr[0] !== 1'b0 || req_rbusy_rr[0] !== 1'b0) begin cnt_err++; $display("FAIL same_done_c3 got=w%b r%b exp=w0 r0", req_wbusy_rr[0], req_rbusy_rr[0]); end
      cycles(1);  // cycle 4
      cnt_cmp++; if (ram_rden_rr !== 1'b0 || ram_addr_rr !== 10'd6) begin cnt_err++; $display("FAIL same_no_read got=%b/%0h exp=0/6", ram_rden_rr, ram_addr_rr); end
      drive_port(0, 32'h18, 32'h0, 4'h0, 1'b1);
      cycles(1);
      clr_in();
      cycles(3);
      cnt_cmp++; if (req_rdata_rr[31:0] !== 32'h0000A5A5) begin cnt_err++; $display("FAIL same_readback got=%0h exp=0000a5a5", req_rdata_rr[31:0]); end
   endtask

   task automatic test_back_to_back();
      drive_port(0, 32'h20, 32'h11111111, 4'hF, 1'b0);
      cycles(1);
      clr_in();
      cycles(1);  // cycle 2
      cnt_cmp++; if (ram_wen_rr !== 1'b1 || ram_addr_rr !== 10'd8) begin cnt_err++; $display("FAIL b2b_first got=%b/%0h exp=1/8", ram_wen_rr, ram_addr_rr); end
      cycles(1);  // cycle 3: busy falls, new strobe accepted now
      cnt_cmp++; if (req_wbusy_rr[0] !== 1'b0) begin cnt_err++; $display("FAIL b2b_fall got=%0h exp=0", req_wbusy_rr[0]); end
      drive_port(0, 32'h24, 32'h22222222, 4'hF, 1'b0);
      cycles(1);  // cycle 4
      clr_in();
      cnt_cmp++; if (req_wbusy_rr[0] !== 1'b1) begin cnt_err++; $display("FAIL b2b_accept got=%0h exp=1", req_wbusy_rr[0]); end
      cycles(1);  // cycle 5
      cnt_cmp++; if (ram_wen_rr !== 1'b1 || ram_addr_rr !== 10'd9 || ram_wdata_rr !== 32'h22222222) begin cnt_err++; $display("FAIL b2b_second got=%b/%0h/%0h exp=1/9/22222222", ram_wen_rr, ram_addr_rr, ram_wdata_rr); end
      cycles(2);
   endtask

   task automatic test_reset_mid();
      drive_port(1, 32'h14, 32'h0, 4'h0, 1'b1);
      cycles(1);
      clr_in();
      cycles(1);  // cycle 2
      cnt_cmp++; if (ram_rden_rr !== 1'b1) begin cnt_err++; $display("FAIL rmid_rden got=%0h exp=1", ram_rden_rr); end
      cycles(1);  // cycle 3, WAIT
      cnt_cmp++; if (req_rbusy_rr[1] !== 1'b1) begin cnt_err++; $display("FAIL rmid_wait got=%0h exp=1", req_rbusy_rr[1]); end
      rst = 1'b1;
      cycles(1);  // cycle 4
      rst = 1'b0;
      cnt_cmp++; if (req_rbusy_rr !== 2'b00 || req_wbusy_rr !== 2'b00) begin cnt_err++; $display("FAIL rmid_busy got=%0h/%0h exp=0/0", req_rbusy_rr, req_wbusy_rr); end
      cnt_cmp++; if (req_rdata_rr !== 64'h0) begin cnt_err++; $display("FAIL rmid_rdata got=%0h exp=0", req_rdata_rr); end
      for (int i = 0; i < 4; i++) begin
         cycles(1);
         cnt_cmp++; if (ram_rden_rr !== 1'b0 || ram_wen_rr !== 1'b0 || req_rdata_rr !== 64'h0) begin cnt_err++; $display("FAIL rmid_quiet[%0d] got=%b%b/%0h exp=00/0", i, ram_rden_rr, ram_wen_rr, req_rdata_rr); end
      end
   endtask

   initial begin
      cnt_cmp = 0;
      cnt_err = 0;
      test_reset();
      test_write();
      test_read();
      test_arb_repeat();
      test_rr_vs_fixed();
      test_force();
      test_wr_rd_same();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_err);
      $finish;
   end

endmodule

// File: doc/pim_mem_arbiter.md
# pim_mem_arbiter

Parametrised N-requester front end for the shared on-chip RAM: each requester (RISC-V core, PIM engine(s), DMA) drives the core-style addr/wdata/wmask/rstrb bus and gets per-port rbusy/wbusy/rdata back. Requests are latched per port and arbitrated round-robin or fixed-priority, with a force override that generalises the single pim_sel mux. The block drives the RAM IP port directly and has no tristate outputs.

## Interface
- NUM_PORTS, 2, number of requesters (2..8); port 0 is the RISC-V core
- ADDR_W, 10, RAM word-address width
- RD_LAT, 1, RAM read latency in cycles from ram_rden to valid ram_rdata (1..3)
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_addr  in  NUM_PORTS*32  byte address per port, port p at [32p+31:32p]
- req_wdata  in  NUM_PORTS*32  write data per port
- req_wmask  in  NUM_PORTS*4  byte write mask; nonzero = write strobe (one cycle)
- req_rstrb  in  NUM_PORTS  read strobe (one cycle)
- req_rdata  out  NUM_PORTS*32  per-port read data register
- req_rbusy  out  NUM_PORTS  read pending for port
- req_wbusy  out  NUM_PORTS  write pending for port
- force_en  in  1  restrict eligibility to force_port only
- force_port  in  $clog2(NUM_PORTS)  forced port index
- ram_addr  out  ADDR_W  word address = captured addr[ADDR_W+1:2]
- ram_wdata  out  32  write data
- ram_wen  out  1  write enable, one cycle
- ram_rden  out  1  read enable, one cycle
- ram_byteena  out  4  wmask on write, 4'hF on read
- ram_rdata  in  32  RAM read data
- active_port  out  $clog2(NUM_PORTS)  port currently granted (debug)

## Operation
- Per-port capture: if port idle (no pending) and wmask!=0 -> latch addr/wdata/wmask, pending write; else if rstrb -> latch addr, pending read. wmask!=0 and rstrb same cycle -> write only, rstrb dropped.
- Strobe while that port is pending: ignored, latched payload unchanged.
- req_rbusy[p] = pending read, req_wbusy[p] = pending write (both registered).
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: eligible = pending & (force_en ? onehot(force_port) : all). If any eligible, pick winner, register RAM outputs from its payload, set active_port, -> ISSUE.
  - ISSUE: ram_wen or ram_rden high exactly this cycle. Write: clear winner pending at end of cycle -> IDLE. Read: -> WAIT.
  - WAIT: count RD_LAT cycles; in last one capture ram_rdata into req_rdata[winner], clear pending -> IDLE.
- Round-robin: search from last_grant+1 upward with wrap; last_grant updated on each grant. Fixed: lowest eligible index.
- force_en evaluated only in IDLE; changing it mid-access does not abort the access. Non-forced pending ports stay busy until eligible.
- req_rdata[p] holds last value until that port's next read completes.
- ram_wen/ram_rden low in all states except ISSUE; ram_addr/wdata/byteena hold last value.

## Timing
- Reset values: all pending 0, req_rbusy/wbusy 0, req_rdata 0, ram_wen/rden 0, ram_addr/wdata/byteena 0, active_port 0, state IDLE, last_grant = NUM_PORTS-1 (port 0 first).
- Reset mid-access: pending requests discarded, no RAM strobe, no rdata update.
- Uncontended write: strobe cycle 0, wbusy high cycles 1-2, ram_wen cycle 2, wbusy low cycle 3.
- Uncontended read (RD_LAT=1): rstrb cycle 0, rbusy high 1-3, ram_rden cycle 2, rdata valid and rbusy low cycle 4. General: rbusy low at cycle 3+RD_LAT.
- Strobe into an idle port captured same cycle it is presented; new strobe accepted the cycle busy falls.
- Throughput: one write per 2 cycles, one read per 2+RD_LAT cycles.

## Test plan
- Port 0 write addr 0x10, wdata 0xDEADBEEF, wmask 4'hF -> ram_wen cycle 2, ram_addr 4, byteena F; wbusy 1 for cycles 1-2.
- Port 1 read addr 0x10 after that write, RAM model RD_LAT=1 -> ram_rden cycle 2, req_rdata[1]=0xDEADBEEF and rbusy low cycle 4; req_rdata[0] unchanged.
- ARB_MODE=0, ports 0 and 1 read same cycle, repeated 4 times -> grant order 0,1,0,1...; ARB_MODE=1 -> port 0 first every time.
- force_en=1, force_port=1, ports 0 and 1 pending -> only port 1 served, port 0 rbusy stays 1; deassert force_en -> port 0 completes.
- Simultaneous wmask=4'h3 and rstrb on port 0 -> write with byteena 3, no read, rbusy stays 0; second strobe during busy ignored.
- rst asserted during WAIT -> all busies 0 next cycle, no rdata update, no ram_rden/wen.
